// File: rtl/clz_seq_chunked.sv
// Iterative leading-zero / leading-sign counter. It scans the captured operand one chunk per cycle
// from the MSB and stops at the first non-zero chunk. It has valid/ready handshakes on both sides.
module clz_seq_chunked #(
    parameter int bits_in  = 16,
    parameter int chunk    = 4,
    parameter int bits_out = $clog2(bits_in) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [bits_in-1:0]  b,
    input  logic                mode,
    input  logic                vin,
    output logic                ready,
    output logic [bits_out-1:0] pout,
    output logic                zero,
    output logic                vout,
    input  logic                rin,
    output logic [1:0]          dbg_state_o
);

    // Handshake rule on both ports: a transfer happens on a posedge where valid and ready are both
    // high. A producer holds valid and its data until that edge. A consumer may hold ready low
    // for as long as it likes. The output side keeps vout/pout/zero frozen until rin accepts them.

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [bits_in-1:0]  sh_q, sh_d;
    logic [bits_out-1:0] cnt_q, cnt_d;
    logic [bits_out-1:0] pout_q, pout_d;
    logic                zero_q, zero_d;

    logic [chunk-1:0]    top;
    logic [bits_out-1:0] top_lz;
    logic [bits_out-1:0] cnt_step;

    assign top      = sh_q[bits_in-1 -: chunk];
    assign cnt_step = cnt_q + bits_out'(chunk);

    // Priority encoder within the top chunk. The highest set bit is visited last, so it wins.
    always_comb begin
        top_lz = bits_out'(chunk);
        for (int i = 0; i < chunk; i++) begin
            if (top[i]) top_lz = bits_out'(chunk - 1 - i);
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        pout_d  = pout_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (vin && ready) begin
                    // A negative operand is inverted so that CLS becomes CLZ of the captured value.
                    sh_d    = (mode && b[bits_in-1]) ? ~b : b;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (top == '0) begin
                    cnt_d = cnt_step;
                    sh_d  = sh_q << chunk;
                    if (cnt_step == bits_out'(bits_in)) begin
                        pout_d  = bits_out'(bits_in);
                        zero_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    pout_d  = cnt_q + top_lz;
                    zero_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rin) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            zero_q  <= zero_d;
        end
    end

    assign ready       = (state_q == S_IDLE) && rst;
    assign vout        = (state_q == S_DONE);
    assign pout        = pout_q;
    assign zero        = zero_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clz_seq_chunked.sv
// Directed bench for clz_seq_chunked: reset, CLZ/CLS vectors, backpressure, streaming,
// and a parameter sweep (chunk 1/2/16, 32-bit operand) against a bit-loop reference.
module tb_clz_seq_chunked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mode, vin, rin;
    logic [15:0] b;
    logic        ready, vout, zero;
    logic [4:0]  pout;
    logic [1:0]  dbg_state;

    logic [15:0] b_s;
    logic [31:0] b_w;
    logic        mode_s, vin_s;
    logic        r_c1, r_c2, r_c16, r_w;
    logic        v_c1, v_c2, v_c16, v_w;
    logic        z_c1, z_c2, z_c16, z_w;
    logic [4:0]  p_c1, p_c2, p_c16;
    logic [5:0]  p_w;
    logic [1:0]  d_c1, d_c2, d_c16, d_w;

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] exp_q[$];

    clz_seq_chunked #(.bits_in(16), .chunk(4)) u_dut (
        .clk(clk), .rst(rst), .b(b), .mode(mode), .vin(vin), .ready(ready),
        .pout(pout), .zero(zero), .vout(vout), .rin(rin), .dbg_state_o(dbg_state));
    clz_seq_chunked #(.bits_in(16), .chunk(1)) u_c1 (
        .clk(clk), .rst(rst), .b(b_s), .mode(mode_s), .vin(vin_s), .ready(r_c1),
        .pout(p_c1), .zero(z_c1), .vout(v_c1), .rin(1'b1), .dbg_state_o(d_c1));
    clz_seq_chunked #(.bits_in(16), .chunk(2)) u_c2 (
        .clk(clk), .rst(rst), .b(b_s), .mode(mode_s), .vin(vin_s), .ready(r_c2),
        .pout(p_c2), .zero(z_c2), .vout(v_c2), .rin(1'b1), .dbg_state_o(d_c2));
    clz_seq_chunked #(.bits_in(16), .chunk(16)) u_c16 (
        .clk(clk), .rst(rst), .b(b_s), .mode(mode_s), .vin(vin_s), .ready(r_c16),
        .pout(p_c16), .zero(z_c16), .vout(v_c16), .rin(1'b1), .dbg_state_o(d_c16));
    clz_seq_chunked #(.bits_in(32), .chunk(4)) u_w32 (
        .clk(clk), .rst(rst), .b(b_w), .mode(mode_s), .vin(vin_s), .ready(r_w),
        .pout(p_w), .zero(z_w), .vout(v_w), .rin(1'b1), .dbg_state_o(d_w));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Main-DUT transaction with rin high. Latency counts edges from accept to first vout-high cycle.
    task automatic do_op(input string tag, input logic [15:0] v, input logic m,
                         input logic [4:0] ep, input logic ez, input int en);
        int lat;
        chk({tag, " ready"}, 32'(ready), 32'd1);
        b = v; mode = m; vin = 1'b1;
        @(negedge clk);
        vin = 1'b0; b = 16'($urandom); mode = ~m;
        chk({tag, " early_vout"}, 32'(vout), 32'd0);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!vout && lat < 40);
        chk({tag, " lat"}, 32'(lat), 32'(en));
        chk({tag, " pout"}, 32'(pout), 32'(ep));
        chk({tag, " zero"}, 32'(zero), 32'(ez));
        @(negedge clk);
        chk({tag, " vout_drop"}, 32'(vout), 32'd0);
        chk({tag, " ready_back"}, 32'(ready), 32'd1);
    endtask

    function automatic int ref_cnt(input logic [31:0] v, input int w, input logic m);
        logic t;
        int c;
        t = m ? v[w-1] : 1'b0;
        c = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (v[i] !== t) break;
            c++;
        end
        return c;
    endfunction

    function automatic int ref_lat(input int cnt, input int w, input int ch);
        return (cnt == w) ? (w / ch) : (cnt / ch + 1);
    endfunction

    task automatic sweep_op(input logic [15:0] v, input logic [31:0] w, input logic m);
        int l1, l2, l16, lw, c16, c32;
        logic [4:0] q1, q2, q16;
        logic [5:0] qw;
        logic y1, y2, y16, yw;
        l1 = 0; l2 = 0; l16 = 0; lw = 0;
        q1 = '0; q2 = '0; q16 = '0; qw = '0;
        y1 = 0; y2 = 0; y16 = 0; yw = 0;
        chk("sweep ready", 32'({r_c1, r_c2, r_c16, r_w}), 32'hF);
        b_s = v; b_w = w; mode_s = m; vin_s = 1'b1;
        @(negedge clk);
        vin_s = 1'b0; b_s = ~v; b_w = ~w; mode_s = ~m;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (v_c1 && l1 == 0)  begin l1 = i;  q1 = p_c1;  y1 = z_c1;  end
            if (v_c2 && l2 == 0)  begin l2 = i;  q2 = p_c2;  y2 = z_c2;  end
            if (v_c16 && l16 == 0) begin l16 = i; q16 = p_c16; y16 = z_c16; end
            if (v_w && lw == 0)   begin lw = i;  qw = p_w;   yw = z_w;   end
        end
        c16 = ref_cnt({16'h0, v}, 16, m);
        c32 = ref_cnt(w, 32, m);
        chk("c1 pout", 32'(q1), 32'(c16));
        chk("c1 zero", 32'(y1), 32'(c16 == 16));
        chk("c1 lat", 32'(l1), 32'(ref_lat(c16, 16, 1)));
        chk("c2 pout", 32'(q2), 32'(c16));
        chk("c2 zero", 32'(y2), 32'(c16 == 16));
        chk("c2 lat", 32'(l2), 32'(ref_lat(c16, 16, 2)));
        chk("c16 pout", 32'(q16), 32'(c16));
        chk("c16 zero", 32'(y16), 32'(c16 == 16));
        chk("c16 lat", 32'(l16), 32'(ref_lat(c16, 16, 16)));
        chk("w32 pout", 32'(qw), 32'(c32));
        chk("w32 zero", 32'(yw), 32'(c32 == 32));
        chk("w32 lat", 32'(lw), 32'(ref_lat(c32, 32, 4)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hits, guard;
        logic [15:0] ops [4];
        logic [4:0]  exps [4];
        int          lats [4];
        logic [15:0] rv;
        logic [31:0] rw;
        logic        rm;

        rst = 1'b0; vin = 1'b0; b = '0; mode = 1'b0; rin = 1'b1;
        vin_s = 1'b0; b_s = '0; b_w = '0; mode_s = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst vout", 32'(vout), 32'd0);
        chk("rst pout", 32'(pout), 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst ready", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst release ready", 32'(ready), 32'd1);

        // CLZ vectors
        do_op("clz ffff", 16'hFFFF, 1'b0, 5'd0, 1'b0, 1);
        do_op("clz 00ff", 16'h00FF, 1'b0, 5'd8, 1'b0, 3);
        do_op("clz 0001", 16'h0001, 1'b0, 5'd15, 1'b0, 4);
        do_op("clz 0000", 16'h0000, 1'b0, 5'd16, 1'b1, 4);
        // CLS vectors
        do_op("cls ff00", 16'hFF00, 1'b1, 5'd8, 1'b0, 3);
        do_op("cls 8000", 16'h8000, 1'b1, 5'd1, 1'b0, 1);
        do_op("cls ffff", 16'hFFFF, 1'b1, 5'd16, 1'b1, 4);
        do_op("cls 3fff", 16'h3FFF, 1'b1, 5'd2, 1'b0, 1);

        // Reset asserted for two cycles while a zero operand is mid-scan.
        b = 16'h0000; mode = 1'b0; vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midrst vout", 32'(vout), 32'd0);
            chk("midrst pout", 32'(pout), 32'd0);
            chk("midrst zero", 32'(zero), 32'd0);
            chk("midrst ready", 32'(ready), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst release ready", 32'(ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vout) hits++;
        end
        chk("midrst stale vout", 32'(hits), 32'd0);

        // Backpressure: result held in DONE while inputs churn.
        rin = 1'b0;
        b = 16'h0F00; mode = 1'b0; vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!vout && lat < 40);
        chk("bp lat", 32'(lat), 32'd2);
        chk("bp pout", 32'(pout), 32'd4);
        for (int i = 0; i < 5; i++) begin
            b = 16'($urandom); mode = 1'($urandom); vin = 1'b1;
            @(negedge clk);
            chk("bp hold vout", 32'(vout), 32'd1);
            chk("bp hold pout", 32'(pout), 32'd4);
            chk("bp hold zero", 32'(zero), 32'd0);
            chk("bp hold ready", 32'(ready), 32'd0);
        end
        rin = 1'b1;
        @(negedge clk);
        chk("bp release vout", 32'(vout), 32'd0);
        chk("bp release ready", 32'(ready), 32'd1);
        vin = 1'b0;
        @(negedge clk);
        chk("bp no accept in done", 32'(ready), 32'd1);

        // Back-to-back stream with vin held high.
        ops[0] = 16'h1234; exps[0] = 5'd3;  lats[0] = 1;
        ops[1] = 16'h0000; exps[1] = 5'd16; lats[1] = 4;
        ops[2] = 16'h00F0; exps[2] = 5'd8;  lats[2] = 3;
        ops[3] = 16'hF000; exps[3] = 5'd0;  lats[3] = 1;
        mode = 1'b0; vin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            guard = 0;
            while (!ready && guard < 20) begin @(negedge clk); guard++; end
            chk("stream ready", 32'(ready), 32'd1);
            b = ops[k];
            exp_q.push_back(exps[k]);
            @(negedge clk);
            b = 16'hA5A5;
            lat = 0;
            do begin @(negedge clk); lat++; end while (!vout && lat < 40);
            chk("stream lat", 32'(lat), 32'(lats[k]));
            chk("stream pout", 32'(pout), 32'(exp_q.pop_front()));
            @(negedge clk);
            chk("stream bubble vout", 32'(vout), 32'd0);
            chk("stream bubble ready", 32'(ready), 32'd1);
        end
        vin = 1'b0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vout) hits++;
        end
        chk("stream extra vout", 32'(hits), 32'd0);

        // Parameter sweep: directed corners then random operands with varied leading runs.
        sweep_op(16'h0000, 32'h0000_0000, 1'b0);
        sweep_op(16'hFFFF, 32'hFFFF_FFFF, 1'b1);
        sweep_op(16'h0001, 32'h0000_0001, 1'b0);
        sweep_op(16'h8000, 32'h8000_0000, 1'b1);
        sweep_op(16'h0400, 32'h0001_0000, 1'b0);
        for (int r = 0; r < 10; r++) begin
            rm = 1'($urandom_range(0, 1));
            rv = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            rw = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) begin
                rv = ~rv;
                rw = ~rw;
            end
            sweep_op(rv, rw, rm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
